// File: rtl/spmv_row_collector.sv
// spmv_row_collector
//   Collects per-cycle partial-product beats from the SpMV multiplier and
//   sums every beat belonging to one output row into a DATA_W accumulator.
//   Each closed row is pushed as {row, sum} into a show-ahead result FIFO.
//   A valid/ready handshake drains the FIFO. The upstream multiplier cannot
//   be stalled, so lost entries or beats raise a sticky overflow flag.
//
//   Optional build macro: COLLECT_SKIP_ZERO_EN -- rows whose final sum is 0
//   are not pushed.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   valid      beat present this cycle
//   zeros      beat carries an empty row (op1/op2 ignored)
//   addrext    row index of the beat
//   op1, op2   two's-complement partial products
//   flush      one-cycle pulse closing the last row of a run
//   res_ready  consumer accepts the head entry
//   res_valid  FIFO not empty
//   res_row    row index of the head entry
//   res_data   row sum of the head entry
//   busy       state is not IDLE (registered)
//   done       one-cycle pulse when a flush completes
//   overflow   sticky: an entry or beat was dropped
module spmv_row_collector #(
  parameter int FIFO_DEPTH = 8,
  parameter int ROW_W      = 10,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              zeros,
  input  logic [ROW_W-1:0]  addrext,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic              flush,
  input  logic              res_ready,
  output logic              res_valid,
  output logic [ROW_W-1:0]  res_row,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [ROW_W-1:0]  cur_row;

  entry_t            mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic [DATA_W-1:0] contrib;
  logic              close_req, push_req, pop, full, push_ok, push_drop;

  assign contrib = zeros ? '0 : op1 + op2;

  // A row closes on a row change while accumulating, or unconditionally in
  // FLUSH. In both cases the entry is the current {cur_row, acc}.
  always_comb begin
    close_req = 1'b0;
    case (state)
      ACCUM:   close_req = valid && (addrext != cur_row);
      FLUSH:   close_req = 1'b1;
      default: close_req = 1'b0;
    endcase
  end

`ifdef COLLECT_SKIP_ZERO_EN
  assign push_req = close_req && (acc != '0);
`else
  assign push_req = close_req;
`endif

  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands.
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && full && !pop;

  assign res_row  = mem[rd_ptr].row;
  assign res_data = mem[rd_ptr].data;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= '{row: cur_row, data: acc};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      cur_row  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push_drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (valid) begin
            acc     <= contrib;
            cur_row <= addrext;
            state   <= flush ? FLUSH : ACCUM;
            busy    <= 1'b1;
          end else if (flush) begin
            done <= 1'b1;
          end
        end
        ACCUM: begin
          // The beat is processed before a coincident flush takes effect.
          if (valid) begin
            if (addrext == cur_row) begin
              acc <= acc + contrib;
            end else begin
              acc     <= contrib;
              cur_row <= addrext;
            end
          end
          if (flush) state <= FLUSH;
        end
        FLUSH: begin
          done  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
          // No beat may arrive while the last row is being pushed.
          if (valid) overflow <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_collector.sv
// Self-checking bench for spmv_row_collector: a table of directed vectors
// followed by hand-written sequences for backpressure, overflow,
// simultaneous valid+flush and mid-run reset.
module tb_spmv_row_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, zeros, flush, res_ready;
  logic [9:0]  addrext;
  logic [63:0] op1, op2;
  logic        res_valid;
  logic [9:0]  res_row;
  logic [63:0] res_data;
  logic        busy, done, overflow;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  spmv_row_collector dut (
    .clk(clk), .reset(reset), .valid(valid), .zeros(zeros),
    .addrext(addrext), .op1(op1), .op2(op2), .flush(flush),
    .res_ready(res_ready), .res_valid(res_valid), .res_row(res_row),
    .res_data(res_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, z;
    logic [9:0]  r;
    logic [63:0] a, b;
    logic        f, rdy;
    logic        ev;
    logic [9:0]  erow;
    logic [63:0] edata;
    logic        ebusy, edone, eovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic [9:0] r, input logic [63:0] d);
    chk({nm, ".res_valid"}, 64'(res_valid), 64'd1);
    chk({nm, ".res_row"},   64'(res_row),   64'(r));
    chk({nm, ".res_data"},  res_data,       d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    valid = 0; zeros = 0; flush = 0; addrext = '0; op1 = '0; op2 = '0;
  endtask

  task automatic beat(input logic [9:0] r, input logic [63:0] a, input logic [63:0] b);
    valid = 1; zeros = 0; flush = 0; addrext = r; op1 = a; op2 = b;
  endtask

  task automatic addv(input logic v, input logic z, input logic [9:0] r,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic f, input logic rdy, input logic ev,
                      input logic [9:0] erow, input logic [63:0] edata,
                      input logic ebusy, input logic edone, input logic eovf);
    vec_t t;
    t.v = v; t.z = z; t.r = r; t.a = a; t.b = b; t.f = f; t.rdy = rdy;
    t.ev = ev; t.erow = erow; t.edata = edata;
    t.ebusy = ebusy; t.edone = edone; t.eovf = eovf;
    tbl.push_back(t);
  endtask

  initial begin
    logic [9:0]  exp_row[$];
    logic [63:0] exp_dat[$];

    // row accumulation: {3,15} then {4,10}
    //   v  z  r  a     b   f  rdy ev row data  busy done ovf
    addv(1, 0, 3, 5,    7,  0, 0,  0, 0, 0,     1, 0, 0);
    addv(1, 0, 3, 1,    2,  0, 0,  0, 0, 0,     1, 0, 0);
    addv(1, 0, 4, 10,   0,  0, 0,  1, 3, 15,    1, 0, 0);
    addv(0, 0, 0, 0,    0,  1, 0,  1, 3, 15,    1, 0, 0);
    addv(0, 0, 0, 0,    0,  0, 0,  1, 3, 15,    0, 1, 0);
    addv(0, 0, 0, 0,    0,  0, 1,  1, 4, 10,    0, 0, 0);
    addv(0, 0, 0, 0,    0,  0, 1,  0, 0, 0,     0, 0, 0);
    // zeros row followed by row 5 = 1+1
    addv(1, 1, 2, ALL1, ALL1, 0, 0, 0, 0, 0,    1, 0, 0);
`ifdef COLLECT_SKIP_ZERO_EN
    addv(1, 0, 5, 1,    1,  0, 0,  0, 0, 0,     1, 0, 0);
    addv(0, 0, 0, 0,    0,  1, 0,  0, 0, 0,     1, 0, 0);
    addv(0, 0, 0, 0,    0,  0, 0,  1, 5, 2,     0, 1, 0);
    addv(0, 0, 0, 0,    0,  0, 1,  0, 0, 0,     0, 0, 0);
`else
    addv(1, 0, 5, 1,    1,  0, 0,  1, 2, 0,     1, 0, 0);
    addv(0, 0, 0, 0,    0,  1, 0,  1, 2, 0,     1, 0, 0);
    addv(0, 0, 0, 0,    0,  0, 0,  1, 2, 0,     0, 1, 0);
    addv(0, 0, 0, 0,    0,  0, 1,  1, 5, 2,     0, 0, 0);
`endif
    addv(0, 0, 0, 0,    0,  0, 1,  0, 0, 0,     0, 0, 0);
    // wrap-around: all-ones + 2 = 1, no overflow
    addv(1, 0, 1, ALL1, 2,  0, 0,  0, 0, 0,     1, 0, 0);
    addv(0, 0, 0, 0,    0,  1, 0,  0, 0, 0,     1, 0, 0);
    addv(0, 0, 0, 0,    0,  0, 0,  1, 1, 1,     0, 1, 0);
    addv(0, 0, 0, 0,    0,  0, 1,  0, 0, 0,     0, 0, 0);
    // flush in IDLE: done pulse only
    addv(0, 0, 0, 0,    0,  1, 0,  0, 0, 0,     0, 1, 0);
    addv(0, 0, 0, 0,    0,  0, 0,  0, 0, 0,     0, 0, 0);

    // reset state
    reset = 0; res_ready = 0; idle_in();
    #1;
    chk("rst.res_valid", 64'(res_valid), 0);
    chk("rst.busy",      64'(busy),      0);
    chk("rst.done",      64'(done),      0);
    chk("rst.overflow",  64'(overflow),  0);
    chk("rst.res_row",   64'(res_row),   0);
    chk("rst.res_data",  res_data,       0);
    tick(); tick();
    reset = 1;
    tick();

    foreach (tbl[i]) begin
      valid = tbl[i].v; zeros = tbl[i].z; addrext = tbl[i].r;
      op1 = tbl[i].a; op2 = tbl[i].b; flush = tbl[i].f; res_ready = tbl[i].rdy;
      tick();
      chk($sformatf("v%0d.res_valid", i), 64'(res_valid), 64'(tbl[i].ev));
      chk($sformatf("v%0d.busy", i),      64'(busy),      64'(tbl[i].ebusy));
      chk($sformatf("v%0d.done", i),      64'(done),      64'(tbl[i].edone));
      chk($sformatf("v%0d.overflow", i),  64'(overflow),  64'(tbl[i].eovf));
      if (tbl[i].ev) chk_head($sformatf("v%0d", i), tbl[i].erow, tbl[i].edata);
    end
    idle_in(); res_ready = 0;

    // valid row 6 together with flush while accumulating row 5
    beat(5, 3, 4); tick();
    beat(5, 1, 0); tick();
    beat(6, 2, 2); flush = 1; tick();
    chk_head("sim.first", 5, 8);
    chk("sim.busy", 64'(busy), 1);
    idle_in(); tick();
    chk("sim.done", 64'(done), 1);
    chk_head("sim.hold", 5, 8);
    res_ready = 1; tick();
    chk_head("sim.second", 6, 4);
    tick();
    chk("sim.empty", 64'(res_valid), 0);
    chk("sim.overflow", 64'(overflow), 0);
    res_ready = 0;

    // backpressure: rows 0..9, FIFO holds 8
    for (int i = 0; i < 10; i++) begin
      beat(10'(i), 64'(100 + i), 64'(i)); tick();
      if (i == 8) chk("bp.ovf_before", 64'(overflow), 0);
      if (i == 9) chk("bp.ovf_after",  64'(overflow), 1);
    end
    idle_in(); flush = 1; tick();
    idle_in(); tick();
    chk("bp.done", 64'(done), 1);
    chk("bp.overflow", 64'(overflow), 1);
    chk_head("bp.head0", 0, 100);

    // full FIFO: a push with a simultaneous pop lands, one without is dropped
    res_ready = 1; beat(30, 30, 0); tick();     // pop row 0, start row 30
    res_ready = 0; beat(31, 31, 0); tick();     // push row 30, FIFO full
    chk_head("bp.head1", 1, 102);
    res_ready = 1; beat(32, 32, 0); tick();     // push row 31 with pop of row 1
    res_ready = 0; idle_in(); flush = 1; tick();
    idle_in(); tick();                          // push row 32 into full FIFO: dropped
    for (int i = 2; i < 8; i++) begin
      exp_row.push_back(10'(i)); exp_dat.push_back(64'(100 + 2 * i));
    end
    exp_row.push_back(30); exp_dat.push_back(30);
    exp_row.push_back(31); exp_dat.push_back(31);
    res_ready = 1;
    foreach (exp_row[i]) begin
      chk_head($sformatf("drain%0d", i), exp_row[i], exp_dat[i]);
      tick();
    end
    chk("drain.empty", 64'(res_valid), 0);
    chk("drain.overflow", 64'(overflow), 1);
    res_ready = 0;

    // reset mid-row discards everything
    beat(7, 5, 5); tick();
    beat(8, 1, 0); tick();
    chk_head("mid.pre", 7, 10);
    reset = 0;
    #2;
    chk("mid.res_valid", 64'(res_valid), 0);
    chk("mid.busy",      64'(busy),      0);
    chk("mid.done",      64'(done),      0);
    chk("mid.overflow",  64'(overflow),  0);
    chk("mid.res_row",   64'(res_row),   0);
    chk("mid.res_data",  res_data,       0);
    idle_in();
    tick();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post%0d.res_valid", i), 64'(res_valid), 0);
      chk($sformatf("post%0d.busy", i),      64'(busy),      0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
